// File: rtl/issue_scoreboard_pkg.sv
// Shared types for the in-order issue scoreboard.
// Optional build macro SCOREBOARD_WB_BYPASS_EN (see issue_scoreboard.sv).
package issue_scoreboard_pkg;

  typedef logic [4:0] reg_idx_t;

  typedef enum logic [1:0] {
    SB_RUN    = 2'd0,
    SB_DRAIN  = 2'd1,
    SB_SERIAL = 2'd2
  } sb_state_t;

  typedef enum logic [1:0] {
    STALL_NONE   = 2'd0,
    STALL_HAZARD = 2'd1,
    STALL_MULDIV = 2'd2,
    STALL_SERIAL = 2'd3
  } stall_cause_t;

  // One-hot register mask, all-zero when not enabled.
  function automatic logic [31:0] reg_onehot(input reg_idx_t idx, input logic en);
    reg_onehot = en ? (32'd1 << idx) : 32'd0;
  endfunction

endpackage

// File: rtl/issue_scoreboard_muldiv_busy_cnt.sv
// Structural occupancy counter for the multi-cycle mul/div unit.
// A load sets the counter to MULDIV_LAT-1; it then counts down to zero.
// busy_o is high while the counter is non-zero.
module muldiv_busy_cnt
  import issue_scoreboard_pkg::*;
#(
  parameter int MULDIV_LAT = 4,
  localparam int CNT_W     = $clog2(MULDIV_LAT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic load_i,
  output logic busy_o
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MULDIV_LAT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear beats load, load beats the saturating decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)              cnt_d = '0;
    else if (load_i)          cnt_d = LOAD_VAL;
    else if (cnt_q != '0)     cnt_d = cnt_q - CNT_W'(1);
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/issue_scoreboard.sv
// In-order issue scoreboard between decode and execute.
// Stalls on RAW/WAW hazards against in-flight destinations, on a busy
// mul/div unit, and drains/serializes around serializing instructions.
// Optional macro SCOREBOARD_WB_BYPASS_EN: a writeback in the current cycle
// already hides its register from the hazard and drain checks.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int MULDIV_LAT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dec_valid_i,
  output logic        dec_ready_o,
  input  logic [4:0]  rs1_i,
  input  logic        rs1_v_i,
  input  logic [4:0]  rs2_i,
  input  logic        rs2_v_i,
  input  logic [4:0]  rd_i,
  input  logic        rd_v_i,
  input  logic        muldiv_i,
  input  logic        serial_i,
  output logic        issue_o,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_rd_i,
  input  logic        serial_done_i,
  input  logic        flush_i,
  output logic [31:0] pending_o,
  output logic [1:0]  stall_cause_o
);

  logic [31:0]  pending_q, pending_d;
  logic [31:0]  pend_view;
  logic [31:0]  wb_mask;
  sb_state_t    state_q, state_d;
  stall_cause_t cause_q, cause_d;
  logic         busy;
  logic         hazard;
  logic         md_stall;
  logic         empty;
  logic         ready_raw;
  logic         issue;

  assign wb_mask = reg_onehot(wb_rd_i, wb_valid_i);

`ifdef SCOREBOARD_WB_BYPASS_EN
  assign pend_view = pending_q & ~wb_mask;
`else
  assign pend_view = pending_q;
`endif

  // x0 never creates a dependence; pending[0] is also held at zero.
  assign hazard = (rs1_v_i & (rs1_i != 5'd0) & pend_view[rs1_i]) |
                  (rs2_v_i & (rs2_i != 5'd0) & pend_view[rs2_i]) |
                  (rd_v_i  & (rd_i  != 5'd0) & pend_view[rd_i]);
  assign md_stall = muldiv_i & busy;
  assign empty    = (pend_view == 32'd0) & ~busy;

  // FSM next state and raw ready; flush forces RUN.
  always_comb begin
    state_d   = state_q;
    ready_raw = 1'b0;
    case (state_q)
      SB_RUN: begin
        if (serial_i) begin
          ready_raw = empty;
          if (dec_valid_i) state_d = empty ? SB_SERIAL : SB_DRAIN;
        end else begin
          ready_raw = ~hazard & ~md_stall;
        end
      end
      SB_DRAIN: begin
        ready_raw = empty;
        if (dec_valid_i & empty) state_d = SB_SERIAL;
      end
      SB_SERIAL: begin
        if (serial_done_i) state_d = SB_RUN;
      end
      default: state_d = SB_RUN;
    endcase
    if (flush_i) state_d = SB_RUN;
  end

  assign dec_ready_o = ready_raw & ~reset & ~flush_i;
  assign issue       = dec_valid_i & dec_ready_o;
  assign issue_o     = issue;

  // Pending vector: clear on writeback, then set on issue so set wins.
  always_comb begin
    pending_d = pending_q & ~wb_mask;
    if (issue) pending_d = pending_d | reg_onehot(rd_i, rd_v_i);
    pending_d[0] = 1'b0;
    if (flush_i) pending_d = 32'd0;
  end

  // Stall cause for a held instruction: serialize > hazard > muldiv.
  always_comb begin
    cause_d = STALL_NONE;
    if (!flush_i && dec_valid_i && !dec_ready_o) begin
      if ((state_q != SB_RUN) || serial_i) cause_d = STALL_SERIAL;
      else if (hazard)                     cause_d = STALL_HAZARD;
      else if (md_stall)                   cause_d = STALL_MULDIV;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= 32'd0;
      state_q   <= SB_RUN;
      cause_q   <= STALL_NONE;
    end else begin
      pending_q <= pending_d;
      state_q   <= state_d;
      cause_q   <= cause_d;
    end
  end

  muldiv_busy_cnt #(.MULDIV_LAT(MULDIV_LAT)) u_busy (
    .clk     (clk),
    .reset   (reset),
    .clear_i (flush_i),
    .load_i  (issue & muldiv_i),
    .busy_o  (busy)
  );

  assign pending_o     = pending_q;
  assign stall_cause_o = cause_q;

endmodule
